ttrng_vn_packer: RTL
====================

// Module: ttrng_vn_packer
// PURPOSE
//  Downstream conditioning stage for the tt_um_ttrng SR-latch entropy network.
//  - Synchronises the raw entropy bit and runs a repetition-count health test.
//  - Removes bias with a von Neumann extractor.
//  - Packs debiased bits into bytes and presents them on a valid/ready output.
// PARAMETERS
//  REP_LIMIT  32  consecutive identical samples that trip health_fail (>=2)
//  SYNC_DEPTH 2   synchroniser flops on raw_bit (>=2)
// PORTS
//  clk          in   1  single design clock
//  rst_n        in   1  reset, synchronous, active-low
//  ena          in   1  sample enable; low = freeze all sampling state
//  raw_bit      in   1  asynchronous entropy bit from the latch network
//  clr_fail     in   1  one-cycle pulse, clears health_fail and overflow
//  out_data     out  8  packed random byte
//  out_valid    out  1  out_data holds an undelivered byte
//  out_ready    in   1  consumer accepts byte when out_valid&&out_ready
//  health_fail  out  1  sticky repetition-count failure
//  overflow     out  1  sticky: completed byte dropped, holding reg full
// BEHAVIOUR
//  Reset (rst_n==0 at posedge clk):
//   - sync chain, prev, rep_cnt, shift reg, bit count, out_data: 0.
//   - out_valid, health_fail, overflow: 0. Pair FSM -> FIRST.
//   - Reset wins over every other event, including mid-byte and mid-pair.
//  Synchroniser: raw_bit -> SYNC_DEPTH flops, clocked every cycle regardless of ena.
//   - Call the last stage s. A raw change is visible on s SYNC_DEPTH edges later.
//  Sample: each posedge with ena=1 consumes s. With ena=0 no state changes
//   except the synchroniser and output handshake.
//  Health test, on every sample:
//   - rep_cnt = (s==prev && rep_cnt!=0) ? sat(rep_cnt+1, REP_LIMIT) : 1; prev <= s.
//   - When the new rep_cnt == REP_LIMIT: health_fail <= 1 on the same edge.
//   - On that edge also: bit count <= 0, shift reg <= 0, out_valid <= 0
//     (held byte discarded), FSM -> FIRST.
//   - While health_fail=1, the extractor emits no bits; the health test keeps running.
//  Pair FSM, while health_fail=0:
//   - FIRST:  a <= s; -> SECOND.
//   - SECOND: if a!=s emit bit a (10->1, 01->0); 00/11 discard; -> FIRST.
//  Packer:
//   - Emitted bit: shift <= {shift[6:0],bit}, cnt <= cnt+1 (3-bit).
//   - The first bit of a byte ends in out_data[7].
//  Byte completion (8th bit, cnt wraps 7->0 on the same edge):
//   - Holding reg free (out_valid==0, or out_valid&&out_ready this cycle):
//     out_data <= {shift[6:0],bit}; out_valid <= 1, visible the next cycle.
//   - Otherwise: byte dropped, overflow <= 1, held byte unchanged.
//  Handshake:
//   - out_data is stable while out_valid && !out_ready.
//   - A transfer without a simultaneous new byte clears out_valid.
//   - out_data is not cleared after a transfer.
//  clr_fail:
//   - Clears health_fail and overflow; rep_cnt <= 0; FSM -> FIRST.
//   - If the same edge also trips the health test, health_fail stays 1.
// TESTING
//  SYNC_DEPTH=2, REP_LIMIT=32. Align raw_bit to the 2-cycle sync delay.
//  1 Reset: rst_n=0 for 2 clk with raw_bit toggling
//    -> out_valid=0, out_data=0, health_fail=0, overflow=0.
//  2 Pack: ena=1, out_ready=1; pairs 10,01,11,10,10,00,01,01,10,01
//    -> out_data=8'hB2; out_valid high exactly 1 cycle.
//  3 Backpressure: out_ready=0; bytes 8'hA5 then 8'h3C
//    -> out_data stays A5, overflow=1; out_ready=1 -> A5 accepted once, 3C never seen.
//  4 Health: raw_bit=1 for 31 samples -> health_fail=0; 32nd sample -> health_fail=1,
//    out_valid=0. clr_fail pulse -> 0. Normal pairs then produce bytes again.
//  5 ena gap: capture pair first bit=1, ena=0 for 10 clk with raw toggling,
//    ena=1, next sample 0 -> bit 1 emitted; rep_cnt unchanged across the gap.
//  6 Mid-byte reset: 5 bits packed, rst_n=0 1 clk; 8 further bits forming 8'h5A
//    -> out_data=8'h5A (no stale bits).

Source files
------------

// File: rtl/ttrng_vn_packer.sv
`default_nettype none
// ============================================================================
// Module   : ttrng_vn_packer
// Purpose  : Entropy conditioning: sync, repetition-count health test, von
//            Neumann debias, byte packing onto a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module ttrng_vn_packer #(
    parameter int REP_LIMIT  = 32,
    parameter int SYNC_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       raw_bit,
    input  logic       clr_fail,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       health_fail,
    output logic       overflow
);

    localparam int                 c_REP_W   = $clog2(REP_LIMIT + 1);
    localparam logic [c_REP_W-1:0] c_REP_MAX = c_REP_W'(REP_LIMIT);
    localparam logic [c_REP_W-1:0] c_REP_ONE = c_REP_W'(1);

    typedef enum logic [0:0] {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } pair_state_t;

    logic [SYNC_DEPTH-1:0] r_sync;
    logic                  r_prev;
    logic [c_REP_W-1:0]    r_rep_cnt;
    logic                  r_health_fail;
    logic                  r_overflow;
    pair_state_t           r_state;
    pair_state_t           w_state_next;
    logic                  r_a;
    logic [7:0]            r_shift;
    logic [2:0]            r_cnt;
    logic [7:0]            r_out_data;
    logic                  r_out_valid;

    logic                  w_s;
    logic [c_REP_W-1:0]    w_rep_next;
    logic                  w_trip;
    logic                  w_emit_en;
    logic                  w_bit_vld;
    logic                  w_byte_done;
    logic                  w_free;
    logic                  w_load;
    logic                  w_drop;
    logic [7:0]            w_shift_next;

    assign w_s = r_sync[SYNC_DEPTH-1];

    // Synchroniser runs every cycle, independent of ena
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], raw_bit};
        end
    end

    assign w_rep_next = (w_s == r_prev && r_rep_cnt != '0)
                      ? ((r_rep_cnt == c_REP_MAX) ? c_REP_MAX : r_rep_cnt + c_REP_ONE)
                      : c_REP_ONE;
    assign w_trip     = ena && (w_rep_next == c_REP_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev    <= 1'b0;
            r_rep_cnt <= '0;
        end else begin
            if (ena) begin
                r_prev <= w_s;
            end
            if (clr_fail) begin
                r_rep_cnt <= '0;
            end else if (ena) begin
                r_rep_cnt <= w_rep_next;
            end
        end
    end

    // A trip on the same edge as clr_fail keeps the failure flagged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_health_fail <= 1'b0;
        end else if (w_trip) begin
            r_health_fail <= 1'b1;
        end else if (clr_fail) begin
            r_health_fail <= 1'b0;
        end
    end

    assign w_emit_en = ena && !r_health_fail && !clr_fail && !w_trip;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FIRST;
            r_a     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_emit_en && r_state == ST_FIRST) begin
                r_a <= w_s;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clr_fail || w_trip) begin
            w_state_next = ST_FIRST;
        end else if (w_emit_en) begin
            case (r_state)
                ST_FIRST:  w_state_next = ST_SECOND;
                ST_SECOND: w_state_next = ST_FIRST;
                default:   w_state_next = ST_FIRST;
            endcase
        end
    end

    assign w_bit_vld    = w_emit_en && (r_state == ST_SECOND) && (r_a != w_s);
    assign w_shift_next = {r_shift[6:0], r_a};
    assign w_byte_done  = w_bit_vld && (r_cnt == 3'd7);
    assign w_free       = !r_out_valid || out_ready;
    assign w_load       = w_byte_done && w_free;
    assign w_drop       = w_byte_done && !w_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= 8'h00;
            r_cnt   <= 3'd0;
        end else if (w_trip) begin
            r_shift <= 8'h00;
            r_cnt   <= 3'd0;
        end else if (w_bit_vld) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 3'd1;
        end
    end

    // Holding register: a trip discards any undelivered byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
        end else if (w_trip) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_shift_next;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (clr_fail) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign health_fail = r_health_fail;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire
